serial_slave_port: RTL
======================

Name: serial_slave_port

Overview:
- Slave-side endpoint of the serial bus. It sits directly downstream of address_decoder, and the decoder's per-slave tx/rx lines connect straight to it.
- Deserialises a bit-serial read/write request, performs the access on a local synchronous memory, and serialises a response back.
- Supports split transactions: while busy is high, the response is held back and the port stays occupied.

Parameters:
- ADDR_W, 12, width of the slave-local address field in the request frame.
- DATA_W, 8, width of the data word.
- MEM_DEPTH, 2048, number of implemented words. Addresses >= MEM_DEPTH are out of range.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- rx  in  1  serial request from address_decoder. Idle high; one bit per clk.
- tx  out  1  serial response to address_decoder. Idle high; one bit per clk; registered.
- busy  in  1  split request. While high, a completed request is held and no response is sent.
- ready  out  1  high only in IDLE; tells the decoder the slave can accept a frame.
- frame_err  out  1  one-cycle pulse when a request's stop bit is sampled as 0.

Behaviour:
- Reset (rstn=0 at an edge) from any state, including mid-frame or mid-response:
  - state returns to IDLE; tx=1, ready=1, frame_err=0 on the next edge.
  - all shift registers and counters are cleared.
  - memory contents are NOT cleared.
- Request frame, LSB first, one bit per cycle:
  - start bit 0
  - mode bit (1=write, 0=read)
  - ADDR_W address bits
  - DATA_W data bits (write only)
  - stop bit 1
- States: IDLE, RX_MODE, RX_ADDR, RX_DATA, RX_STOP, EXEC, HOLD, TX_START, TX_STATUS, TX_DATA, TX_STOP.
- IDLE: rx=0 sampled -> RX_MODE; rx=1 -> stay.
- RX_MODE: latch mode -> RX_ADDR.
- RX_ADDR: shift ADDR_W bits; bit counter from 0 to ADDR_W-1 -> RX_DATA if write, RX_STOP if read.
- RX_DATA: shift DATA_W bits -> RX_STOP.
- RX_STOP:
  - rx=1 -> EXEC.
  - rx=0 -> pulse frame_err, discard request (no memory access, no response) -> IDLE.
- EXEC (single cycle):
  - in_range = (addr < MEM_DEPTH).
  - Write and in range: memory write this cycle.
  - Read and in range: memory read issued; data valid the next cycle (1-cycle synchronous read).
  - Out of range: no memory access.
  - Always -> HOLD.
- HOLD:
  - busy=1 -> stay (split); tx held at 1.
  - busy=0 -> TX_START.
- Response frame:
  - TX_START drives tx=0.
  - TX_STATUS drives 0 for OK, 1 for out-of-range.
  - TX_DATA drives DATA_W read-data bits LSB first; only for an in-range read.
  - TX_STOP drives 1, then -> IDLE.
- Latency: with busy low throughout, the response start bit appears on tx exactly 3 cycles after the cycle in which the request stop bit is sampled.
- Response length:
  - in-range read: 3+DATA_W bits.
  - write, or any out-of-range request: 3 bits.
- ready deasserts in the cycle after the start bit is sampled and reasserts when IDLE is re-entered.
- Half-duplex: rx is ignored outside IDLE. A start bit arriving during HOLD or TX is lost; the decoder must respect ready.
- busy changes after TX_START are ignored; a response in progress always completes.
- busy high while in IDLE or any RX state has no effect until HOLD.
- Back-to-back frames: a new start bit is accepted in the first IDLE cycle after TX_STOP.

Decomposition:
- Shared package serial_bus_pkg:
  - mode encoding constants (MODE_READ=0, MODE_WRITE=1).
  - status constants (ST_OK=0, ST_RANGE_ERR=1).
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - state enum type.
  - the master, decoder and this port all share the frame encoding.
- Sub-module slave_mem: single-port synchronous RAM with MEM_DEPTH x DATA_W, inputs we/addr/wdata, output rdata, 1-cycle read latency, no reset.

Test Plan:
- Write then read:
  - Stimulus: write addr 0x005, data 0xA5, busy=0; then read addr 0x005.
  - Required: write response is bits 0,0,1; read response is 0,0, then 0xA5 LSB first (1,0,1,0,0,1,0,1), then 1.
- Out of range:
  - Stimulus: read addr 0x800 (2048).
  - Required: response 0,1,1; memory unchanged; a re-read of 0x005 still returns 0xA5.
- Split:
  - Stimulus: busy=1 before the stop bit of a read of 0x005; busy released 20 cycles later.
  - Required: tx stays 1 and ready stays 0 throughout HOLD; start bit appears 1 cycle after busy falls; data is 0xA5.
- Framing error:
  - Stimulus: write frame to addr 0x010 with stop bit 0.
  - Required: frame_err pulses for exactly 1 cycle; no response; ready=1 the next cycle; a read of 0x010 returns the prior contents.
- Reset mid-operation:
  - Stimulus: rstn low for 1 cycle during TX_DATA.
  - Required: tx=1 and ready=1 the next cycle; the next frame is processed normally; memory retains 0xA5 at 0x005.
- Back-to-back with latency check:
  - Stimulus: two writes issued immediately after each other's TX_STOP.
  - Required: both are acknowledged; each start bit arrives exactly 3 cycles after its request stop bit.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Frame encoding and state type shared by the serial bus master, decoder and slave port.
package serial_bus_pkg;

  localparam logic MODE_READ    = 1'b0;
  localparam logic MODE_WRITE   = 1'b1;

  localparam logic ST_OK        = 1'b0;
  localparam logic ST_RANGE_ERR = 1'b1;

  localparam logic START_BIT    = 1'b0;
  localparam logic STOP_BIT     = 1'b1;
  localparam logic IDLE_LEVEL   = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    RX_MODE,
    RX_ADDR,
    RX_DATA,
    RX_STOP,
    EXEC,
    HOLD,
    TX_START,
    TX_STATUS,
    TX_DATA,
    TX_STOP
  } slave_state_e;

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous RAM with one-cycle read latency; contents are not reset.
module slave_mem #(
  parameter int unsigned MEM_DEPTH = 2048,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write on we; read port continuously registers the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: deserialises a request, accesses local memory,
// serialises the response; busy holds a completed request (split transaction).
module serial_slave_port
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 2048
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx,
  input  logic busy,
  output logic ready,
  output logic frame_err
);

  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_MX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W  = $clog2(CNT_MX + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  slave_state_e      state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              status_q, status_d;
  logic [DATA_W-1:0] txsh_q, txsh_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              ferr_q, ferr_d;

  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  slave_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_W    (DATA_W),
    .MEM_AW    (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[MEM_AW-1:0]),
    .wdata (data_q),
    .rdata (mem_rdata)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = '0;
    status_d = status_q;
    txsh_d   = txsh_q;
    ferr_d   = 1'b0;
    mem_we   = 1'b0;
    in_range = ({1'b0, addr_q} < DEPTH_L);

    case (state_q)
      IDLE:    if (rx == START_BIT) state_d = RX_MODE;
      RX_MODE: begin
        mode_d  = rx;
        state_d = RX_ADDR;
      end
      RX_ADDR: begin
        addr_d = {rx, addr_q[ADDR_W-1:1]};
        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
          state_d = (mode_q == MODE_WRITE) ? RX_DATA : RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        data_d = {rx, data_q[DATA_W-1:1]};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx == STOP_BIT) begin
          state_d = EXEC;
        end else begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      EXEC: begin
        status_d = in_range ? ST_OK : ST_RANGE_ERR;
        mem_we   = (mode_q == MODE_WRITE) && in_range;
        state_d  = HOLD;
      end
      HOLD: begin
        // Address is stable here, so read data stays valid for any hold length.
        if (!busy) begin
          txsh_d  = mem_rdata;
          state_d = TX_START;
        end
      end
      TX_START:  state_d = TX_STATUS;
      TX_STATUS: state_d = ((mode_q == MODE_READ) && (status_q == ST_OK)) ? TX_DATA : TX_STOP;
      TX_DATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = TX_STOP;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          txsh_d = txsh_q >> 1;
        end
      end
      TX_STOP:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // tx is decoded from the next state so the line changes with the state register.
    case (state_d)
      TX_START:  tx_d = START_BIT;
      TX_STATUS: tx_d = status_d;
      TX_DATA:   tx_d = txsh_d[0];
      TX_STOP:   tx_d = STOP_BIT;
      default:   tx_d = IDLE_LEVEL;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      mode_q   <= MODE_READ;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      status_q <= ST_OK;
      txsh_q   <= '0;
      tx_q     <= IDLE_LEVEL;
      ready_q  <= 1'b1;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      txsh_q   <= txsh_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      ferr_q   <= ferr_d;
    end
  end

  assign tx        = tx_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;

endmodule
